// File: rtl/icache_refill_axi_bridge.sv
// ICache line-refill bridge: turns one refill request into a single AXI4 INCR read burst
// and returns the assembled line in one cycle.
module icache_refill_axi_bridge #(
  parameter int         DATA_WIDTH    = 32,
  parameter int         LINE_WORD_NUM = 4,
  parameter logic [3:0] AXI_ID        = 4'd0
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_rd_req,
  input  logic [31:0]                           i_rd_addr,
  output logic                                  o_rd_rdy,
  output logic                                  o_ret_valid,
  output logic [LINE_WORD_NUM*DATA_WIDTH-1:0]   o_ret_data,
  output logic                                  o_ret_err,
  output logic [3:0]                            o_arid,
  output logic [31:0]                           o_araddr,
  output logic [7:0]                            o_arlen,
  output logic [2:0]                            o_arsize,
  output logic [1:0]                            o_arburst,
  output logic                                  o_arvalid,
  input  logic                                  i_arready,
  input  logic [3:0]                            i_rid,
  input  logic [DATA_WIDTH-1:0]                 i_rdata,
  input  logic [1:0]                            i_rresp,
  input  logic                                  i_rlast,
  input  logic                                  i_rvalid,
  output logic                                  o_rready
);
  localparam int          CNT_W      = $clog2(LINE_WORD_NUM);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LINE_WORD_NUM - 1);
  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_WORD_NUM * 4) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                                   r_state, w_next;
  logic [31:0]                              r_addr;
  logic [CNT_W-1:0]                         r_cnt;
  logic                                     r_err;
  logic                                     r_over;
  logic [LINE_WORD_NUM-1:0][DATA_WIDTH-1:0] r_line;
  logic                                     w_accept, w_beat;
  logic                                     w_unused_rid;

  // Responses are not matched by ID: only one burst is ever outstanding.
  assign w_unused_rid = ^i_rid;

  assign w_accept   = (r_state == S_IDLE) & i_rd_req;
  assign w_beat     = (r_state == S_R) & i_rvalid;
  assign o_araddr   = r_addr;
  assign o_arlen    = 8'(LINE_WORD_NUM - 1);
  assign o_arsize   = 3'b010;
  assign o_arburst  = 2'b01;
  assign o_arid     = AXI_ID;
  assign o_ret_data = r_line;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_rd_rdy    = 1'b0;
    o_arvalid   = 1'b0;
    o_rready    = 1'b0;
    o_ret_valid = 1'b0;
    o_ret_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_rd_rdy = 1'b1;
        if (i_rd_req) w_next = S_AR;
      end
      S_AR: begin
        o_arvalid = 1'b1;
        if (i_arready) w_next = S_R;
      end
      S_R: begin
        o_rready = 1'b1;
        if (i_rvalid && i_rlast) w_next = S_DONE;
      end
      S_DONE: begin
        o_ret_valid = 1'b1;
        o_ret_err   = r_err;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_over marks that a full line has landed without rlast; later beats are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_over <= 1'b0;
      r_line <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= i_rd_addr & ALIGN_MASK;
        r_cnt  <= '0;
        r_err  <= 1'b0;
        r_over <= 1'b0;
      end
      if (w_beat) begin
        if (!r_over) begin
          r_line[r_cnt] <= i_rdata;
          r_cnt         <= r_cnt + CNT_W'(1);
        end
        if ((i_rresp != 2'b00) || r_over || (i_rlast && (r_cnt != LAST)))
          r_err <= 1'b1;
        if (!i_rlast && (r_cnt == LAST))
          r_over <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_icache_refill_axi_bridge.sv
// Directed bench for icache_refill_axi_bridge: cycle-exact checks of the AR/R handshakes,
// line assembly, error reporting and asynchronous reset.
module tb_icache_refill_axi_bridge;
  logic         clk = 1'b0, rst = 1'b1;
  logic         rd_req = 1'b0;
  logic [31:0]  rd_addr = '0;
  logic         rd_rdy, ret_valid, ret_err;
  logic [127:0] ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, rready;
  logic         arready = 1'b0;
  logic [3:0]   rid = 4'h5;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0, rvalid = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  icache_refill_axi_bridge #(.DATA_WIDTH(32), .LINE_WORD_NUM(4), .AXI_ID(4'd0)) dut (
    .i_clk(clk), .i_rst(rst), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_rdy(rd_rdy), .o_ret_valid(ret_valid), .o_ret_data(ret_data), .o_ret_err(ret_err),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
    .o_arburst(arburst), .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid),
    .o_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Full refill transaction; beat k carries base+k, and beat err_beat answers SLVERR.
  task automatic run_refill(input string nm, input logic [31:0] addr, input logic [31:0] exp_addr,
                            input int ar_delay, input int gap, input int nbeats, input int last_idx,
                            input int err_beat, input logic [31:0] base,
                            input logic [127:0] exp_line, input logic exp_err);
    rd_req = 1'b1; rd_addr = addr;
    mid(); chk({nm, ".accept_rdy"}, rd_rdy, 1);
    step(); rd_req = 1'b0;
    for (int d = 0; d < ar_delay; d++) begin
      mid();
      chk({nm, ".arwait_valid"}, arvalid, 1);
      chk({nm, ".arwait_addr"}, araddr, exp_addr);
      chk({nm, ".arwait_len"}, arlen, 3);
      chk({nm, ".arwait_rdy"}, rd_rdy, 0);
      step();
    end
    arready = 1'b1;
    mid();
    chk({nm, ".arvalid"}, arvalid, 1);
    chk({nm, ".araddr"}, araddr, exp_addr);
    chk({nm, ".arlen"}, arlen, 3);
    chk({nm, ".arsize"}, arsize, 3'b010);
    chk({nm, ".arburst"}, arburst, 2'b01);
    chk({nm, ".arid"}, arid, 0);
    chk({nm, ".ar_rready"}, rready, 0);
    chk({nm, ".ar_rdy"}, rd_rdy, 0);
    step(); arready = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          rvalid = 1'b0;
          mid();
          chk({nm, ".gap_rready"}, rready, 1);
          chk({nm, ".gap_retv"}, ret_valid, 0);
          chk({nm, ".gap_rdy"}, rd_rdy, 0);
          step();
        end
      end
      rvalid = 1'b1; rdata = base + 32'(k);
      rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      rlast  = (k == last_idx);
      mid();
      chk({nm, ".beat_rready"}, rready, 1);
      chk({nm, ".beat_arvalid"}, arvalid, 0);
      chk({nm, ".beat_rdy"}, rd_rdy, 0);
      chk({nm, ".beat_retv"}, ret_valid, 0);
      step();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    mid();
    chk({nm, ".ret_valid"}, ret_valid, 1);
    chk({nm, ".ret_data"}, ret_data, exp_line);
    chk({nm, ".ret_err"}, ret_err, exp_err);
    chk({nm, ".done_rready"}, rready, 0);
    chk({nm, ".done_rdy"}, rd_rdy, 0);
    step();
    mid();
    chk({nm, ".post_retv"}, ret_valid, 0);
    chk({nm, ".post_rdy"}, rd_rdy, 1);
    chk({nm, ".post_data"}, ret_data, exp_line);
    step();
  endtask

  localparam logic [127:0] L_B2B1 = {32'h103, 32'h102, 32'h101, 32'h100};
  localparam logic [127:0] L_B2B2 = {32'h203, 32'h202, 32'h201, 32'h200};

  initial begin
    // Reset values, checked before any clock edge.
    #2;
    chk("rst.rd_rdy", rd_rdy, 1);
    chk("rst.ret_valid", ret_valid, 0);
    chk("rst.ret_err", ret_err, 0);
    chk("rst.ret_data", ret_data, 0);
    chk("rst.arvalid", arvalid, 0);
    chk("rst.rready", rready, 0);
    chk("rst.araddr", araddr, 0);
    chk("rst.arlen", arlen, 3);
    chk("rst.arsize", arsize, 3'b010);
    chk("rst.arburst", arburst, 2'b01);
    chk("rst.arid", arid, 0);
    step(); rst = 1'b0;

    run_refill("basic", 32'h1FC0_0014, 32'h1FC0_0010, 0, 0, 4, 3, -1, 32'hA0,
               {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
    run_refill("bkpr", 32'h0000_1238, 32'h0000_1230, 3, 2, 4, 3, -1, 32'hB0,
               {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0);
    run_refill("slverr", 32'h2000_0004, 32'h2000_0000, 0, 0, 4, 3, 2, 32'hC0,
               {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b1);
    run_refill("clean", 32'h2000_0040, 32'h2000_0040, 1, 1, 4, 3, -1, 32'hD0,
               {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b0);
    // Early rlast: words 2/3 keep the previous line's values.
    run_refill("short", 32'h0000_300C, 32'h0000_3000, 0, 0, 2, 1, -1, 32'hE0,
               {32'hD3, 32'hD2, 32'hE1, 32'hE0}, 1'b1);
    // Fifth beat must not wrap onto word 0.
    run_refill("long", 32'h0000_4000, 32'h0000_4000, 0, 0, 5, 4, -1, 32'hF0,
               {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 1'b1);

    // Back-to-back with rd_req held high.
    rd_req = 1'b1; rd_addr = 32'h0000_0100;
    mid(); chk("b2b.accept1", rd_rdy, 1);
    step(); arready = 1'b1;
    mid(); chk("b2b.araddr1", araddr, 32'h0000_0100);
    step(); arready = 1'b0; rd_addr = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rdata = 32'h100 + 32'(k); rlast = (k == 3);
      mid(); step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    mid();
    chk("b2b.retv1", ret_valid, 1);
    chk("b2b.data1", ret_data, L_B2B1);
    chk("b2b.done_rdy", rd_rdy, 0);
    step();
    mid();
    chk("b2b.accept2", rd_rdy, 1);
    chk("b2b.hold_idle", ret_data, L_B2B1);
    step(); rd_req = 1'b0; arready = 1'b1;
    mid();
    chk("b2b.arvalid2", arvalid, 1);
    chk("b2b.araddr2", araddr, 32'h0000_0200);
    chk("b2b.hold_ar", ret_data, L_B2B1);
    step(); arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rdata = 32'h200 + 32'(k); rlast = (k == 3);
      mid();
      if (k == 0) chk("b2b.hold_beat0", ret_data, L_B2B1);
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    mid();
    chk("b2b.retv2", ret_valid, 1);
    chk("b2b.data2", ret_data, L_B2B2);
    chk("b2b.err2", ret_err, 0);
    step(); step();

    // Async reset in the middle of R, after beat 1.
    rd_req = 1'b1; rd_addr = 32'h0000_6000;
    mid(); step(); rd_req = 1'b0; arready = 1'b1;
    mid(); step(); arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1; rdata = 32'h60 + 32'(k);
      mid(); step();
    end
    rvalid = 1'b0;
    mid(); chk("arst.pre_rready", rready, 1);
    #2 rst = 1'b1; rvalid = 1'b1; rdata = 32'h62;
    #1;
    chk("arst.rready", rready, 0);
    chk("arst.arvalid", arvalid, 0);
    chk("arst.rd_rdy", rd_rdy, 1);
    chk("arst.ret_valid", ret_valid, 0);
    chk("arst.ret_data", ret_data, 0);
    chk("arst.araddr", araddr, 0);
    step(); rst = 1'b0; rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mid();
      chk("arst.no_retv", ret_valid, 0);
      chk("arst.idle_rready", rready, 0);
      chk("arst.idle_data", ret_data, 0);
      step();
    end
    run_refill("post_rst", 32'h5555_5557, 32'h5555_5550, 0, 0, 4, 3, -1, 32'h10,
               {32'h13, 32'h12, 32'h11, 32'h10}, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/icache_refill_axi_bridge.md
# icache_refill_axi_bridge

Responder end of the cache line-refill interface: accepts one line-refill request from the instruction cache (`rd_req`/`rd_addr`), issues a single AXI4 INCR burst read on the system bus, and collects the beats into a line buffer. It returns the whole line in one cycle with `ret_valid`. It sits between the ICache miss path and the AXI interconnect read channels.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; AXI data width equals this.
- `LINE_WORD_NUM`, 4: words per cache line, which is also the burst length. Must be a power of two, 2..16.
- `AXI_ID`, 4'd0: constant ARID driven on every burst.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `rd_req` input 1: cache requests a line refill.
- `rd_addr` input 32: refill address. Offset bits are ignored.
- `rd_rdy` output 1: bridge can accept a request. A request is accepted when `rd_req & rd_rdy`.
- `ret_valid` output 1: one-cycle pulse meaning the line is available on `ret_data`.
- `ret_data` output LINE_WORD_NUM*DATA_WIDTH: returned line. Word i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ret_err` output 1: qualified by `ret_valid`. High if any beat had a nonzero RRESP or the burst length was wrong.
- `arid` output 4, `araddr` output 32, `arlen` output 8, `arsize` output 3, `arburst` output 2, `arvalid` output 1, `arready` input 1: AXI read-address channel.
- `rid` input 4, `rdata` input DATA_WIDTH, `rresp` input 2, `rlast` input 1, `rvalid` input 1, `rready` output 1: AXI read-data channel.

## Operation
- States are IDLE, AR, R and DONE. Reset forces IDLE.
- **IDLE**
  - `rd_rdy`=1.
  - On accept, latch `rd_addr` with its low log2(LINE_WORD_NUM*4) bits cleared.
  - Clear the beat counter and the error flag, then go to AR.
- **AR**
  - `arvalid`=1.
  - `araddr` = latched line-aligned address.
  - `arlen` = LINE_WORD_NUM-1, `arsize` = 3'b010, `arburst` = 2'b01 (INCR), `arid` = AXI_ID.
  - AR fields stay stable while `arvalid` is high.
  - On `arready`, go to R.
- **R**
  - `rready`=1.
  - Each `rvalid` beat writes `rdata` into line word[cnt], then cnt increments. cnt is log2(LINE_WORD_NUM) bits, and beats beyond LINE_WORD_NUM are not written.
  - `rresp`!=0 on any beat sets the error flag.
  - `rid` is not checked.
  - On a beat with `rlast`=1, go to DONE.
  - If `rlast` arrives with cnt!=LINE_WORD_NUM-1, set the error flag. Words not received keep their stale value.
  - If cnt reaches LINE_WORD_NUM-1 without `rlast`, keep accepting beats until `rlast`. The extra beats are dropped and set the error flag.
- **DONE**
  - `ret_valid`=1 and `ret_err`=error flag for exactly one cycle, then go to IDLE.
- `ret_data` is driven directly from the line buffer. It holds its value from DONE until the next refill's first R beat.
- `rd_rdy`=0 in AR, R and DONE. An `rd_req` held high through DONE is accepted in the following IDLE cycle.
- Only one burst is outstanding at a time; there is no request queuing.

## Timing
- Reset values:
  - `rd_rdy`=1.
  - `ret_valid`=0, `ret_err`=0, `ret_data`=0.
  - `arvalid`=0, `rready`=0, `araddr`=0.
  - `arlen`=LINE_WORD_NUM-1, `arsize`=3'b010, `arburst`=2'b01, `arid`=AXI_ID.
- All outputs are registered or decoded from the state only. No combinational path from any input to any output.
- Accept at cycle T:
  - `arvalid` is high from T+1.
  - With `arready` at T+1, `rready` is high from T+2.
  - With back-to-back beats at T+2..T+1+LINE_WORD_NUM, `ret_valid` is high at T+2+LINE_WORD_NUM.
  - Minimum request-to-return latency is LINE_WORD_NUM+2 cycles.
  - The next accept is no earlier than T+3+LINE_WORD_NUM.
- `rvalid` while not in R is ignored (`rready`=0).
- `arready` while not in AR is ignored.
- `rst` asserted in any state:
  - Immediately drops `arvalid`/`rready` and returns to IDLE.
  - The in-flight AXI burst is abandoned, because the system resets the interconnect together with this block.

## Test plan
- Basic refill:
  - Stimulus: `rd_addr`=0x1FC0_0014, `arready` immediate, beats 0xA0,0xA1,0xA2,0xA3 back-to-back with `rlast` on the 4th.
  - Required: `araddr`=0x1FC0_0010, `arlen`=3, `ret_valid` exactly 6 cycles after accept, `ret_data`={0xA3,0xA2,0xA1,0xA0}, `ret_err`=0.
- Backpressure:
  - Stimulus: `arready` delayed 3 cycles; `rvalid` gapped (beat, idle, idle, beat…).
  - Required: AR fields stable while waiting; words land in order; `ret_valid` one cycle after the `rlast` beat; `rd_rdy`=0 throughout.
- Error response:
  - Stimulus: beat 2 has `rresp`=2'b10.
  - Required: all 4 words captured and `ret_err`=1 with `ret_valid`.
  - Then a clean refill: `ret_err`=0.
- Length mismatch:
  - Stimulus: `rlast` on beat 2.
  - Required: DONE after beat 2 with `ret_err`=1.
  - Stimulus: 5 beats with `rlast` on the 5th.
  - Required: 5th beat dropped, `ret_err`=1, words 0-3 correct.
- Back-to-back:
  - Stimulus: `rd_req` held high across two refills to 0x0000_0100 and 0x0000_0200.
  - Required: second accept in the cycle after `ret_valid`; two distinct bursts; `ret_data` is unchanged between the first `ret_valid` and the first beat of the second burst.
- Async reset:
  - Stimulus: assert `rst` in the middle of R (after beat 1).
  - Required: `rready`/`arvalid` low without waiting for a clock edge, `rd_rdy`=1, `ret_valid` never pulses, `ret_data`=0.
  - A refill issued after reset completes correctly.
